// File: rtl/data_mem.sv
// data_mem: 4096 x 32-bit word-addressed data memory on the load/store path.
// Single-port synchronous write, registered read, write-first on the shared address.
// Reset invalidates every word through a per-word valid bit, so the storage array
// itself is never cleared and can map onto block RAM.
module data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_DM,
  input  logic [DATA_W-1:0] dataDM,
  input  logic [ADDR_W-1:0] addDM,
  output logic [DATA_W-1:0] outDM
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage has no reset, which keeps it inferable as block RAM.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  logic [DATA_W-1:0] ramRd;
  logic [DATA_W-1:0] wrBypass;
  logic              rdSelWr;
  logic              rdHit;
  logic              wrEn;

  // A write seen while reset is held must be dropped.
  assign wrEn = we_DM & rst_n;

  // Array write port.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[addDM] <= dataDM;
    end
  end

  // Array read port: plain registered read (old data on a same-edge write).
  always_ff @(posedge clk) begin
    ramRd <= mem[addDM];
  end

  // One valid flop per word; reset clears them all at once, a write sets its own.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gVld
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld[gi] <= 1'b0;
        end else if (we_DM && (addDM == ADDR_W'(gi))) begin
          vld[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Read qualifiers: remember whether this read was a write (forward the new data)
  // and whether the word was valid. Clearing these forces outDM to 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdSelWr  <= 1'b0;
      rdHit    <= 1'b0;
      wrBypass <= '0;
    end else begin
      rdSelWr  <= we_DM;
      rdHit    <= vld[addDM];
      wrBypass <= dataDM;
    end
  end

  // Output select: forwarded write data, valid stored word, or zero.
  always_comb begin
    outDM = '0;
    if (rdSelWr) begin
      outDM = wrBypass;
    end else if (rdHit) begin
      outDM = ramRd;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: scoreboard bench for data_mem. The driver computes each expected
// read from a simple array model and queues it; a monitor compares outDM one
// edge later against the head of the queue.
module tb_data_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              we_DM;
  logic [DATA_W-1:0] dataDM;
  logic [ADDR_W-1:0] addDM;
  logic [DATA_W-1:0] outDM;

  int tests  = 0;
  int failed = 0;

  // Reference model: what each word should read as.
  logic [DATA_W-1:0] refMem [DEPTH];
  bit                refVld [DEPTH];
  logic [DATA_W-1:0] expQ [$];
  string             nameQ [$];

  data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_DM  (we_DM),
    .dataDM (dataDM),
    .addDM  (addDM),
    .outDM  (outDM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("[TB] ok %s: %08h", name, act);
    end
  endtask

  // One bus cycle: drive on the falling edge, queue the expected read result.
  task automatic cycle(input string name, input bit we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    @(negedge clk);
    we_DM  = we;
    addDM  = a;
    dataDM = d;
    if (we) begin
      expQ.push_back(d);
      refMem[a] = d;
      refVld[a] = 1'b1;
    end else begin
      expQ.push_back(refVld[a] ? refMem[a] : '0);
    end
    nameQ.push_back(name);
  endtask

  // Monitor: every edge out of reset produces one read result.
  always @(posedge clk) begin
    #1;
    if (rst_n && expQ.size() > 0) begin
      check(nameQ.pop_front(), outDM, expQ.pop_front());
    end
  end

  // Asynchronous reset pulse placed between clock edges.
  task automatic midReset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async_out", outDM, '0);
    for (int i = 0; i < DEPTH; i++) refVld[i] = 1'b0;
    // A write presented while reset is held must be ignored.
    we_DM  = 1'b1;
    addDM  = 12'h005;
    dataDM = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("reset_hold_out", outDM, '0);
    @(negedge clk);
    we_DM = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [ADDR_W-1:0] pool [8];
    rst_n  = 1'b0;
    we_DM  = 1'b0;
    addDM  = '0;
    dataDM = '0;
    for (int i = 0; i < DEPTH; i++) begin
      refMem[i] = '0;
      refVld[i] = 1'b0;
    end
    #1;
    check("reset_initial_out", outDM, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cycle("rd_after_reset_001", 1'b0, 12'h001, '0);
    cycle("wr_001", 1'b1, 12'h001, 32'h00001DFE);
    cycle("wr_002", 1'b1, 12'h002, 32'h00001EFE);
    cycle("rd_001", 1'b0, 12'h001, '0);
    cycle("rd_002", 1'b0, 12'h002, '0);
    cycle("wr_001_again", 1'b1, 12'h001, 32'h00001DFE);
    cycle("overwrite_001", 1'b1, 12'h001, 32'h00001001);
    cycle("rd_001_new", 1'b0, 12'h001, '0);
    cycle("rd_002_kept", 1'b0, 12'h002, '0);
    cycle("rdw_7ff", 1'b1, 12'h7FF, 32'hA5A5A5A5);
    cycle("rd_7ff", 1'b0, 12'h7FF, '0);
    cycle("wr_000", 1'b1, 12'h000, 32'hDEADBEEF);
    cycle("wr_fff", 1'b1, 12'hFFF, 32'h12345678);
    cycle("rd_000", 1'b0, 12'h000, '0);
    cycle("rd_fff", 1'b0, 12'hFFF, '0);
    cycle("rd_800_unwritten", 1'b0, 12'h800, '0);
    cycle("hold_we_1", 1'b1, 12'h010, 32'h11111111);
    cycle("hold_we_2", 1'b1, 12'h010, 32'h22222222);
    cycle("rd_010_last", 1'b0, 12'h010, '0);

    midReset();
    cycle("post_rst_001", 1'b0, 12'h001, '0);
    cycle("post_rst_002", 1'b0, 12'h002, '0);
    cycle("post_rst_fff", 1'b0, 12'hFFF, '0);
    cycle("post_rst_005_ignored", 1'b0, 12'h005, '0);
    cycle("rewrite_001", 1'b1, 12'h001, 32'h0BADC0DE);
    cycle("rd_rewritten_001", 1'b0, 12'h001, '0);
    cycle("rd_still_zero_002", 1'b0, 12'h002, '0);

    // Random traffic over a small pool so reads frequently hit written words.
    pool = '{12'h000, 12'h001, 12'h002, 12'h3A5, 12'h7FF, 12'h800, 12'hFFE, 12'hFFF};
    for (int n = 0; n < 300; n++) begin
      cycle("rand", ($urandom_range(0, 2) == 0), pool[$urandom_range(0, 7)], $urandom);
    end
    midReset();
    for (int n = 0; n < 100; n++) begin
      cycle("rand_post_rst", ($urandom_range(0, 3) == 0), pool[$urandom_range(0, 7)],
            $urandom);
    end

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (expQ.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
